uart_prog_loader: RTL
=====================

// Module: uart_prog_loader
// PURPOSE
//   Byte-level UART program loader feeding the upg_* write ports of IFetch (instruction RAM) and DataMem.
//   Receives 8N1 serial bytes and packs every 4 bytes (little-endian) into one 32-bit word.
//   Issues one write pulse per word at an incrementing word address; upg_adr_o[14] selects data memory.
//   Signals done on address-space full or idle timeout; done releases the CPU from programming mode.
// PARAMETERS
//   CLK_HZ        10_000_000  frequency of upg_clk_i in Hz
//   BAUD          128_000     serial bit rate; DIV = CLK_HZ/BAUD clocks per bit (integer, >= 4)
//   ADR_W         15          word-address width; bit ADR_W-1 is the memory select
//   IDLE_TIMEOUT  1_000_000   idle cycles after last byte before done is declared
// PORTS
//   upg_clk_i   in   1        loader clock (single clock domain)
//   upg_rst_i   in   1        synchronous reset, active-high
//   upg_rx_i    in   1        serial input, idle high, asynchronous to upg_clk_i
//   upg_clk_o   out  1        equals upg_clk_i; memory-side write clock
//   upg_wen_o   out  1        one-cycle write strobe per completed word
//   upg_adr_o   out  ADR_W    word address of the current write
//   upg_dat_o   out  32       word data of the current write
//   upg_done_o  out  1        sticky: load finished
//   upg_err_o   out  1        sticky: framing error or trailing partial word
//   upg_tx_o    out  1        serial output (see CONFIGURATION)
// BEHAVIOUR
//   Reset: wen=0, adr=0, dat=0, done=0, err=0, tx=1; byte index, word count, timers, state cleared.
//   Reset mid-word or mid-byte: partial data discarded; the next 4 good bytes write to adr 0.
//   RX: 2-FF synchroniser on upg_rx_i; a falling edge in RX_IDLE starts a byte; start bit re-checked
//     at DIV/2 (high -> false start, back to RX_IDLE); then 8 data bits LSB first, each sampled every DIV;
//     then the stop bit. Stop=0 -> byte dropped, err set, back to RX_IDLE. Stop=1 -> byte_valid pulse.
//   Loader FSM states: L_WAIT (no byte yet), L_RECV (collecting), L_WRITE (one cycle), L_DONE.
//     L_WAIT -> L_RECV on first byte_valid; no timeout runs in L_WAIT.
//     On each byte_valid, byte k (k = 0..3) goes to dat[8k+7:8k]; idle timer cleared.
//     4th byte -> L_WRITE: wen=1 for exactly one cycle with adr/dat valid;
//       adr/dat hold until the next write; adr increments after the strobe.
//     After the write of address 2^ADR_W-1 -> L_DONE (no wrap-around).
//     Otherwise -> L_RECV. Idle timer reaches IDLE_TIMEOUT in L_RECV -> L_DONE.
//       If byte index != 0 at that point: err=1 and the partial word is not written.
//     A byte_valid in the same cycle the timer expires wins: byte accepted, timer cleared.
//   Latency: wen asserts 1 cycle after the 4th byte's byte_valid.
//   L_DONE: done=1 until reset; RX ignored; wen stays 0.
// CONFIGURATION
//   UPG_ECHO_EN defined: each accepted byte is retransmitted 8N1 on upg_tx_o at BAUD.
//     A byte arriving while TX is busy is dropped from the echo only; loading is unaffected.
//   UPG_ECHO_EN undefined: upg_tx_o tied to 1; no TX logic is synthesised.
// STRUCTURE
//   Shared package uart_loader_pkg:
//     loader state encodings (L_WAIT/L_RECV/L_WRITE/L_DONE), RX state encodings, and the DIV/half-DIV
//     localparam function.
//   Sub-module uart_rx_byte(clk, rst, rx, byte_o, byte_valid_o, frame_err_o): synchroniser + bit FSM.
//   Top level holds the word packer, address counter, idle timer, and optional echo transmitter.
// TESTING  (sim params CLK_HZ=10_000_000, BAUD=1_000_000 -> DIV=10, IDLE_TIMEOUT=200)
//   1. Send 78 56 34 12
//      -> one wen pulse, adr=0x0000, dat=0x12345678; done=0, err=0.
//   2. Send 8 bytes (01 00 00 00 02 00 00 00), then idle 250 cycles
//      -> writes adr 0 = 1 and adr 1 = 2; done=1 200 cycles after the last stop bit; err=0.
//   3. Send 5 bytes, then idle
//      -> single write at adr 0; done=1; err=1; no second wen.
//   4. Send byte 0xAA with stop=0, then 4 good bytes 11 22 33 44
//      -> err=1; write adr 0 = 0x44332211 (bad byte dropped).
//   5. ADR_W=4: send 64 bytes
//      -> 16 writes; adr 0..15 with adr[3]=1 from word 8; done=1 right after adr 15; further bytes ignored.
//   6. Assert rst after 2 bytes, then send 4 bytes
//      -> all outputs at reset values; write at adr 0 with the new word.
//      With UPG_ECHO_EN: upg_tx_o repeats each byte; without it upg_tx_o stays 1.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared encodings and baud-divider helpers for the UART program loader.
// Used by uart_rx_byte and uart_prog_loader.
package uart_loader_pkg;

    typedef enum logic [1:0] {
        L_WAIT,
        L_RECV,
        L_WRITE,
        L_DONE
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic int unsigned bit_div(input int unsigned clk_hz,
                                            input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned half_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return bit_div(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling at DIV clocks per bit.
// byte_valid_o / frame_err_o are single-cycle pulses at the stop-bit sample.
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int unsigned DIV  = 10,
    parameter int unsigned HALF = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);
    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    rx_state_e     state_q, state_d;
    logic [2:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          rxs, fall;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value
    assign rxs  = sync_q[1];
    assign fall = sync_q[2] & ~sync_q[1];
    assign byte_o = sh_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 3'b111;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            sync_q  <= {sync_q[1], sync_q[0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        sh_d         = sh_q;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    sh_d  = {rxs, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d        = '0;
                    state_d      = RX_IDLE;
                    byte_valid_o = rxs;
                    frame_err_o  = ~rxs;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: packs little-endian byte quads into word writes.
// Define UPG_ECHO_EN to retransmit each accepted byte on upg_tx_o.
module uart_prog_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 10_000_000,
    parameter int unsigned BAUD         = 128_000,
    parameter int unsigned ADR_W        = 15,
    parameter int unsigned IDLE_TIMEOUT = 1_000_000
) (
    input  logic             upg_clk_i,
    input  logic             upg_rst_i,
    input  logic             upg_rx_i,
    output logic             upg_clk_o,
    output logic             upg_wen_o,
    output logic [ADR_W-1:0] upg_adr_o,
    output logic [31:0]      upg_dat_o,
    output logic             upg_done_o,
    output logic             upg_err_o,
    output logic             upg_tx_o
);
    localparam int unsigned DIV = bit_div(CLK_HZ, BAUD);
    localparam int unsigned TW  = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(IDLE_TIMEOUT - 1);
    localparam logic [ADR_W-1:0] ADR_LAST = '1;

    ld_state_e        state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [23:0]      asm_q, asm_d;
    logic [31:0]      dat_q, dat_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [ADR_W-1:0] wcnt_q, wcnt_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             err_q, err_d;
    logic [7:0]       rx_byte;
    logic             rx_valid, rx_ferr, accept;

    uart_rx_byte #(
        .DIV  (DIV),
        .HALF (half_div(CLK_HZ, BAUD))
    ) u_rx (
        .clk_i        (upg_clk_i),
        .rst_i        (upg_rst_i),
        .rx_i         (upg_rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_ferr)
    );

    assign accept     = rx_valid & ((state_q == L_WAIT) | (state_q == L_RECV));
    assign upg_clk_o  = upg_clk_i;
    assign upg_wen_o  = (state_q == L_WRITE);
    assign upg_done_o = (state_q == L_DONE);
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_err_o  = err_q;

    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i) begin
            state_q <= L_WAIT;
            idx_q   <= '0;
            asm_q   <= '0;
            dat_q   <= '0;
            adr_q   <= '0;
            wcnt_q  <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            dat_q   <= dat_d;
            adr_q   <= adr_d;
            wcnt_q  <= wcnt_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        dat_d   = dat_q;
        adr_d   = adr_q;
        wcnt_d  = wcnt_q;
        tmr_d   = tmr_q;
        err_d   = err_q;
        if (rx_ferr && state_q != L_DONE) err_d = 1'b1;
        unique case (state_q)
            L_WAIT, L_RECV: begin
                // an arriving byte beats a timer expiring in the same cycle
                if (accept) begin
                    tmr_d = '0;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        dat_d   = {rx_byte, asm_q};
                        adr_d   = wcnt_q;
                        state_d = L_WRITE;
                    end else begin
                        asm_d[{idx_q, 3'b000} +: 8] = rx_byte;
                        state_d = L_RECV;
                    end
                end else if (state_q == L_RECV) begin
                    if (tmr_q == TMO_LAST) begin
                        state_d = L_DONE;
                        if (idx_q != 2'd0) err_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            L_WRITE: begin
                tmr_d = tmr_q + 1'b1;
                if (wcnt_q == ADR_LAST) begin
                    state_d = L_DONE;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
                    state_d = L_RECV;
                end
            end
            L_DONE: ;
            default: state_d = L_WAIT;
        endcase
    end

`ifdef UPG_ECHO_EN
    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] TX_LAST = CW'(DIV - 1);

    logic [9:0]    tx_sh_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bits_q;
    logic          tx_busy_q;

    // bytes accepted while a previous echo is in flight are not echoed
    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i) begin
            tx_sh_q   <= '1;
            tx_cnt_q  <= '0;
            tx_bits_q <= '0;
            tx_busy_q <= 1'b0;
        end else if (!tx_busy_q && accept) begin
            tx_sh_q   <= {1'b1, rx_byte, 1'b0};
            tx_cnt_q  <= '0;
            tx_bits_q <= '0;
            tx_busy_q <= 1'b1;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == TX_LAST) begin
                tx_cnt_q <= '0;
                tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
                if (tx_bits_q == 4'd9) tx_busy_q <= 1'b0;
                else tx_bits_q <= tx_bits_q + 4'd1;
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    assign upg_tx_o = tx_busy_q ? tx_sh_q[0] : 1'b1;
`else
    assign upg_tx_o = 1'b1;
`endif

endmodule
